// File: rtl/osc_divider_core.sv
// Purpose : programmable clock-enable / square-wave generator for the UART baud path.
// Latency : divisor loads appear on active_div/reload one edge later; first tick N enabled edges after load.
// Backpress: none; enable low freezes the phase, tick never asserts while enable is low.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   divisor_in       requested divisor from the PIO register (0 = stopped)
//   enable           count enable; low holds phase and osc_out
//   sync_clear       one-cycle request to restart phase and force adoption of divisor_in
//   tick             registered one-cycle pulse every active_div enabled cycles
//   osc_out          registered square wave, toggles on each tick
//   active_div       divisor currently in force
//   reload           registered pulse in the cycle after active_div was (re)loaded
module osc_divider_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] divisor_in,
   input  logic             enable,
   input  logic             sync_clear,
   output logic             tick,
   output logic             osc_out,
   output logic [WIDTH-1:0] active_div,
   output logic             reload
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] div_nxt;
   logic [WIDTH-1:0] div_m1;
   logic             tick_nxt;
   logic             osc_nxt;
   logic             reload_nxt;
   logic             terminal;

   // Only meaningful when active_div != 0; the idle rule takes priority otherwise.
   assign div_m1   = active_div - ONE;
   assign terminal = (cnt == div_m1);

   always_comb begin
      cnt_nxt    = cnt;
      div_nxt    = active_div;
      tick_nxt   = 1'b0;
      osc_nxt    = osc_out;
      reload_nxt = 1'b0;

      if (sync_clear) begin
         // Resync beats a coincident terminal count: no tick is issued.
         div_nxt    = divisor_in;
         cnt_nxt    = '0;
         osc_nxt    = 1'b0;
         reload_nxt = 1'b1;
      end else if (active_div == '0) begin
         cnt_nxt = '0;
         osc_nxt = 1'b0;
         if (divisor_in != '0) begin
            div_nxt    = divisor_in;
            reload_nxt = 1'b1;
         end
      end else if (!enable) begin
         // Disabled is a safe point: adopt a new divisor and restart the phase,
         // but leave osc_out where it is.
         if (divisor_in != active_div) begin
            div_nxt    = divisor_in;
            cnt_nxt    = '0;
            reload_nxt = 1'b1;
         end
      end else if (terminal) begin
         // Period boundary: the current period always completes with its tick,
         // even when the new divisor is 0 (idle then clears osc_out next edge).
         tick_nxt = 1'b1;
         osc_nxt  = ~osc_out;
         cnt_nxt  = '0;
         if (divisor_in != active_div) begin
            div_nxt    = divisor_in;
            reload_nxt = 1'b1;
         end
      end else begin
         // cnt < active_div - 1 here, so the increment cannot wrap.
         cnt_nxt = cnt + ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         active_div <= '0;
         tick       <= 1'b0;
         osc_out    <= 1'b0;
         reload     <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         active_div <= div_nxt;
         tick       <= tick_nxt;
         osc_out    <= osc_nxt;
         reload     <= reload_nxt;
      end
   end

endmodule

// File: tb/tb_osc_divider_core.sv
// Purpose : self-checking bench for osc_divider_core against a countdown reference model.
// Latency : model predicts outputs one edge after each input set.
// Backpress: n/a.
module tb_osc_divider_core;

   localparam int WIDTH = 16;

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] divisor_in;
   logic             enable;
   logic             sync_clear;
   logic             tick;
   logic             osc_out;
   logic [WIDTH-1:0] active_div;
   logic             reload;

   int checks;
   int failures;

   // Reference model: divisor in force, enabled edges left until the next tick,
   // square-wave level and the one-cycle pulses predicted for the next edge.
   int m_div;
   int m_left;
   bit m_osc;
   bit m_tick;
   bit m_reload;

   osc_divider_core #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .divisor_in (divisor_in),
      .enable     (enable),
      .sync_clear (sync_clear),
      .tick       (tick),
      .osc_out    (osc_out),
      .active_div (active_div),
      .reload     (reload)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_div    = 0;
      m_left   = 0;
      m_osc    = 1'b0;
      m_tick   = 1'b0;
      m_reload = 1'b0;
   endtask

   task automatic model_step(input int d, input bit en, input bit sc);
      m_tick   = 1'b0;
      m_reload = 1'b0;
      if (sc) begin
         m_div    = d;
         m_left   = d;
         m_osc    = 1'b0;
         m_reload = 1'b1;
      end else if (m_div == 0) begin
         m_osc = 1'b0;
         if (d != 0) begin
            m_div    = d;
            m_left   = d;
            m_reload = 1'b1;
         end
      end else if (!en) begin
         if (d != m_div) begin
            m_div    = d;
            m_left   = d;
            m_reload = 1'b1;
         end
      end else if (m_left == 1) begin
         m_tick = 1'b1;
         m_osc  = ~m_osc;
         if (d != m_div) begin
            m_div    = d;
            m_reload = 1'b1;
         end
         m_left = m_div;
      end else begin
         m_left = m_left - 1;
      end
   endtask

   task automatic check_outputs();
      chk("tick",       {31'd0, tick},            {31'd0, m_tick});
      chk("osc_out",    {31'd0, osc_out},         {31'd0, m_osc});
      chk("active_div", {16'd0, active_div},      m_div);
      chk("reload",     {31'd0, reload},          {31'd0, m_reload});
   endtask

   // Drive one set of inputs, predict, then sample 1 time unit after the edge.
   task automatic cycle(input int d, input bit en, input bit sc);
      divisor_in = d[WIDTH-1:0];
      enable     = en;
      sync_clear = sc;
      model_step(d, en, sc);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic run(input int d, input bit en, input int n);
      for (int i = 0; i < n; i++) cycle(d, en, 1'b0);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset_n    = 1'b0;
      divisor_in = '0;
      enable     = 1'b0;
      sync_clear = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;

      // Reset and start: idle with divisor 0, then load 4.
      run(0, 1'b1, 20);
      run(4, 1'b1, 14);

      // Change mid-period: 5 then 3 early in a period.
      run(5, 1'b1, 12);
      while (m_left != 4) cycle(5, 1'b1, 1'b0);
      run(3, 1'b1, 12);

      // Stop via zero.
      run(6, 1'b1, 9);
      run(0, 1'b1, 10);

      // Enable gating with hold and a change during hold.
      run(4, 1'b1, 6);
      while (m_left != 2) cycle(4, 1'b1, 1'b0);
      run(4, 1'b0, 3);
      run(4, 1'b1, 8);
      run(7, 1'b0, 2);
      run(7, 1'b1, 16);

      // Sync clear coinciding with a terminal count, then divisor 1.
      run(3, 1'b1, 4);
      while (m_left != 1) cycle(3, 1'b1, 1'b0);
      cycle(3, 1'b1, 1'b1);
      chk("sync_no_tick", {31'd0, tick}, 32'd0);
      run(3, 1'b1, 5);
      cycle(1, 1'b1, 1'b1);
      run(1, 1'b1, 6);

      // Asynchronous reset mid-run at cnt=3 of N=10.
      run(10, 1'b1, 12);
      while (m_left != 7) cycle(10, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_tick",       {31'd0, tick},       32'd0);
      chk("arst_osc",        {31'd0, osc_out},    32'd0);
      chk("arst_active_div", {16'd0, active_div}, 32'd0);
      chk("arst_reload",     {31'd0, reload},     32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      run(10, 1'b1, 25);

      // Randomized traffic with small divisors.
      begin
         int d;
         bit en;
         bit sc;
         d = 3;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) d = $urandom_range(0, 9);
            if ($urandom_range(0, 199) == 0) d = $urandom_range(10, 300);
            en = ($urandom_range(0, 5) != 0);
            sc = ($urandom_range(0, 39) == 0);
            cycle(d, en, sc);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout at %0t: got running expected finished", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/osc_divider_core.md
# osc_divider_core

Programmable clock-enable generator that consumes the 16-bit divisor word driven by the Nios-side oscillator-divisor PIO register. It produces a one-cycle `tick` every `active_div` enabled clock cycles and a 50%-duty `osc_out` square wave, for the UART baud-rate path. Divisor changes are adopted only at safe points: period boundary, idle, disabled, or explicit resync. A software write therefore never produces a runt or stretched period.

## Interface
- `WIDTH`, default 16, width of divisor, counter and `active_div`.
- `clk`  in  1  system clock, same domain as the divisor PIO.
- `reset_n`  in  1  reset, asynchronous, active-low. Clock is `clk`.
- `divisor_in`  in  WIDTH  requested divisor from the PIO output port. 0 means stopped.
- `enable`  in  1  count enable. Low freezes the phase.
- `sync_clear`  in  1  one-cycle request: restart phase and force adoption of `divisor_in`.
- `tick`  out  1  registered one-cycle pulse, once per `active_div` enabled cycles.
- `osc_out`  out  1  registered square wave, toggles on each tick. Period is 2·`active_div` enabled cycles.
- `active_div`  out  WIDTH  divisor currently in force.
- `reload`  out  1  registered one-cycle pulse in the cycle after `active_div` was (re)loaded.

## Operation
- Internal state: `cnt` [WIDTH], `active_div`, `tick`, `osc_out`, `reload`.
- Reset value of every one of these is 0. Reset is asynchronous and may occur mid-period; the counter restarts from 0 after release.
- Per clock edge, the first matching rule applies:
  1. **`sync_clear`=1:** `active_div`←`divisor_in`, `cnt`←0, `osc_out`←0, `tick`←0, `reload`←1.
  2. **`active_div`=0 (IDLE):** `cnt`←0, `tick`←0, `osc_out`←0. If `divisor_in`≠0: `active_div`←`divisor_in`, `reload`←1.
  3. **`enable`=0 (HOLD):** `tick`←0, `cnt`/`osc_out` hold. If `divisor_in`≠`active_div`: adopt it, `cnt`←0, `reload`←1.
  4. **Terminal (`cnt`=`active_div`−1):**
     - `tick`←1, `osc_out`←~`osc_out`, `cnt`←0.
     - If `divisor_in`≠`active_div`: `active_div`←`divisor_in`, `reload`←1.
     - The current period completes with its tick even if the new value is 0; the block then enters IDLE with `osc_out`←0.
  5. **Otherwise (RUN):** `cnt`←`cnt`+1, `tick`←0.
- `reload`←0 on every edge where no load occurs.
- Arithmetic:
  - `active_div`−1 is computed in WIDTH bits and is used only when `active_div`≠0.
  - `cnt` is always < `active_div`, so it never wraps.
  - Max divisor is 2^WIDTH−1.
- `divisor_in` is level-sampled. Intermediate values that change within a running period are ignored; only the value present in the terminal cycle is taken.
- `active_div`=1 with `enable` held high gives `tick` constantly high and `osc_out` toggling every cycle.

## Timing
- Load latency: a `divisor_in` change while IDLE or HOLD, or a `sync_clear`, appears on `active_div` and `reload` one edge later.
- A change while in RUN lands at the next terminal edge.
- First tick: `tick` is high in the cycle exactly N enabled edges after the load edge (N = `active_div`). Subsequent ticks follow every N enabled cycles.
- `enable` low for k cycles delays the next tick by exactly k cycles. `tick` never asserts while `enable` is low.
- `sync_clear` in the same cycle as a terminal count: `sync_clear` wins, and no tick is issued.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset and start:** reset, `divisor_in`=0, `enable`=1 → all outputs 0 for 20 cycles. Then `divisor_in`=4 → `reload` 1 cycle later, `active_div`=4, ticks at load+4, +8, +12, `osc_out` period 8.
- **Change mid-period:** running N=5; write 3 at `cnt`=1 → the current 5-cycle period completes with a tick, `reload` in the same cycle, then ticks every 3 cycles. No short period.
- **Stop via zero:** running N=6; `divisor_in`←0 → the final tick arrives at the boundary, then `tick`=`osc_out`=0 and `cnt`=0 held.
- **Enable gating:** N=4, drop `enable` for 3 cycles at `cnt`=2 → the next tick is delayed by exactly 3 cycles. Changing `divisor_in` to 7 during hold → immediate `reload`, first tick 7 enabled cycles after re-enable.
- **Sync clear and divisor 1:** `sync_clear` coinciding with a terminal count → no tick, `cnt`=0, `osc_out`=0. Then N=1 with `enable`=1 → `tick` high every cycle, `osc_out` alternating.
- **Asynchronous reset mid-run:** assert `reset_n` low asynchronously at `cnt`=3 of N=10 → outputs drop to 0 immediately without waiting for a clock edge, and the sequence restarts cleanly after release.
